// File: rtl/snow64_instr_fetch_if.sv
// ----------------------------------------------------------------------------
// snow64_instr_fetch_if
// Bundles every non-clock/reset signal of the instruction fetch stage.
//   master : the fetch stage (drives memory requests and decoder outputs)
//   slave  : the surroundings (redirect source, memory, decoder)
// Signals:
//   in_redirect_valid / in_redirect_addr   redirect pulse and new fetch PC
//   out_mem_req_valid / out_mem_req_addr   memory read request
//   in_mem_req_ready                       memory accepts request
//   in_mem_resp_valid / in_mem_resp_data   returned instruction word
//   out_instr_valid / out_instr / out_instr_pc  buffered head to decoder
//   in_instr_ready                         decoder consumes head
// ----------------------------------------------------------------------------
interface snow64_instr_fetch_if #(
   parameter int WIDTH__INSTR = 32,
   parameter int WIDTH__ADDR  = 64
);
   logic                    in_redirect_valid;
   logic [WIDTH__ADDR-1:0]  in_redirect_addr;

   logic                    out_mem_req_valid;
   logic [WIDTH__ADDR-1:0]  out_mem_req_addr;
   logic                    in_mem_req_ready;
   logic                    in_mem_resp_valid;
   logic [WIDTH__INSTR-1:0] in_mem_resp_data;

   logic                    out_instr_valid;
   logic [WIDTH__INSTR-1:0] out_instr;
   logic [WIDTH__ADDR-1:0]  out_instr_pc;
   logic                    in_instr_ready;

   modport master (
      input  in_redirect_valid, in_redirect_addr,
      input  in_mem_req_ready, in_mem_resp_valid, in_mem_resp_data,
      input  in_instr_ready,
      output out_mem_req_valid, out_mem_req_addr,
      output out_instr_valid, out_instr, out_instr_pc
   );

   modport slave (
      output in_redirect_valid, in_redirect_addr,
      output in_mem_req_ready, in_mem_resp_valid, in_mem_resp_data,
      output in_instr_ready,
      input  out_mem_req_valid, out_mem_req_addr,
      input  out_instr_valid, out_instr, out_instr_pc
   );
endinterface

// File: rtl/snow64_instr_fetch.sv
// ----------------------------------------------------------------------------
// snow64_instr_fetch
// Instruction fetch stage feeding the decoder. Owns the fetch PC, issues one
// 32-bit read at a time, buffers returned words (tagged with their PC) in a
// small FIFO and presents the FIFO head to the decoder with valid/ready.
// A redirect flushes the FIFO and restarts fetch at the new address.
// Ports:
//   clk  clock, rising edge
//   rst  synchronous active-high reset
//   bus  snow64_instr_fetch_if.master (memory request/response, redirect,
//        decoder handshake)
// ----------------------------------------------------------------------------
module snow64_instr_fetch #(
   parameter int                     WIDTH__INSTR = 32,
   parameter int                     WIDTH__ADDR  = 64,
   parameter logic [WIDTH__ADDR-1:0] RESET_PC     = '0,
   parameter int                     FIFO_DEPTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   snow64_instr_fetch_if.master  bus
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [WIDTH__ADDR-1:0] ALIGN_MASK = {{(WIDTH__ADDR-2){1'b1}}, 2'b00};
   localparam logic [WIDTH__ADDR-1:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT
   } state_t;

   state_t                  state_reg, state_next;
   // fetch_pc: address of the next request to be issued.
   // req_addr: address of the request currently presented / in flight; it is
   // also the PC tag of the word that comes back for it.
   logic [WIDTH__ADDR-1:0]  fetch_pc_reg, fetch_pc_next;
   logic [WIDTH__ADDR-1:0]  req_addr_reg, req_addr_next;
   // discard: the in-flight response belongs to a flushed path.
   // stale: the presented (not yet accepted) request belongs to a flushed path.
   logic                    discard_reg, discard_next;
   logic                    stale_reg, stale_next;

   logic [PTR_W-1:0]        rd_ptr_reg, rd_ptr_next;
   logic [PTR_W-1:0]        wr_ptr_reg, wr_ptr_next;
   logic [CNT_W-1:0]        count_reg, count_next;
   logic [CNT_W-1:0]        remain;

   logic [WIDTH__INSTR-1:0] head_instr_reg, head_instr_next;
   logic [WIDTH__ADDR-1:0]  head_pc_reg, head_pc_next;

   logic [WIDTH__INSTR-1:0] fifo_instr [FIFO_DEPTH];
   logic [WIDTH__ADDR-1:0]  fifo_pc    [FIFO_DEPTH];

   logic                    redirect;
   logic [WIDTH__ADDR-1:0]  redirect_target;
   logic                    pop;
   logic                    accept;
   logic                    resp;
   logic                    push;

   assign redirect        = bus.in_redirect_valid;
   assign redirect_target = bus.in_redirect_addr & ALIGN_MASK;
   assign pop             = (count_reg != '0) && bus.in_instr_ready;
   assign accept          = (state_reg == ST_REQ) && bus.in_mem_req_ready;
   assign resp            = (state_reg == ST_WAIT) && bus.in_mem_resp_valid;
   // A response that meets a redirect is already on the flushed path.
   assign push            = resp && !discard_reg && !redirect;

   // ------------------------------------------------------------------
   // FIFO pointers, occupancy and registered head
   // ------------------------------------------------------------------
   always_comb begin
      rd_ptr_next     = rd_ptr_reg;
      wr_ptr_next     = wr_ptr_reg;
      count_next      = count_reg;
      head_instr_next = head_instr_reg;
      head_pc_next    = head_pc_reg;
      remain          = count_reg - CNT_W'(pop);

      if (redirect) begin
         // Flush: drop everything by catching the read pointer up.
         rd_ptr_next = wr_ptr_reg;
         count_next  = '0;
      end else begin
         if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
         end
         count_next = count_reg + CNT_W'(push) - CNT_W'(pop);

         // Head register tracks the next oldest entry; when the FIFO drains
         // it keeps its last value.
         if (remain != '0) begin
            head_instr_next = fifo_instr[rd_ptr_next];
            head_pc_next    = fifo_pc[rd_ptr_next];
         end else if (push) begin
            head_instr_next = bus.in_mem_resp_data;
            head_pc_next    = req_addr_reg;
         end
      end
   end

   // ------------------------------------------------------------------
   // Fetch FSM
   // ------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      fetch_pc_next = fetch_pc_reg;
      req_addr_next = req_addr_reg;
      discard_next  = discard_reg;
      stale_next    = stale_reg;

      case (state_reg)
         ST_IDLE: begin
            if (redirect) begin
               fetch_pc_next = redirect_target;
            end
            // Nothing is outstanding in IDLE, so occupancy alone decides.
            if (redirect || (count_reg < DEPTH_CNT)) begin
               state_next    = ST_REQ;
               req_addr_next = redirect ? redirect_target : fetch_pc_reg;
            end
         end

         ST_REQ: begin
            if (accept) begin
               state_next = ST_WAIT;
               stale_next = 1'b0;
               if (redirect) begin
                  fetch_pc_next = redirect_target;
                  discard_next  = 1'b1;
               end else if (stale_reg) begin
                  // fetch_pc already holds the redirect target.
                  discard_next = 1'b1;
               end else begin
                  fetch_pc_next = req_addr_reg + WIDTH__ADDR'(4);
               end
            end else if (redirect) begin
               // The request must stay stable until accepted; just remember
               // that its data is unwanted.
               fetch_pc_next = redirect_target;
               stale_next    = 1'b1;
            end
         end

         ST_WAIT: begin
            if (redirect) begin
               fetch_pc_next = redirect_target;
            end
            if (resp) begin
               discard_next = 1'b0;
               // The slot reserved for this response is now either filled or
               // released, so count_next is the true occupancy.
               if (count_next < DEPTH_CNT) begin
                  state_next    = ST_REQ;
                  req_addr_next = redirect ? redirect_target : fetch_pc_reg;
               end else begin
                  state_next = ST_IDLE;
               end
            end else if (redirect) begin
               discard_next = 1'b1;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         fetch_pc_reg   <= RESET_PC_ALIGNED;
         req_addr_reg   <= RESET_PC_ALIGNED;
         discard_reg    <= 1'b0;
         stale_reg      <= 1'b0;
         rd_ptr_reg     <= '0;
         wr_ptr_reg     <= '0;
         count_reg      <= '0;
         head_instr_reg <= '0;
         head_pc_reg    <= '0;
      end else begin
         state_reg      <= state_next;
         fetch_pc_reg   <= fetch_pc_next;
         req_addr_reg   <= req_addr_next;
         discard_reg    <= discard_next;
         stale_reg      <= stale_next;
         rd_ptr_reg     <= rd_ptr_next;
         wr_ptr_reg     <= wr_ptr_next;
         count_reg      <= count_next;
         head_instr_reg <= head_instr_next;
         head_pc_reg    <= head_pc_next;
      end
   end

   // FIFO storage: one register pair per entry, cleared on reset.
   generate
      for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (rst) begin
               fifo_instr[gi] <= '0;
               fifo_pc[gi]    <= '0;
            end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
               fifo_instr[gi] <= bus.in_mem_resp_data;
               fifo_pc[gi]    <= req_addr_reg;
            end
         end
      end
   endgenerate

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.out_mem_req_valid = (state_reg == ST_REQ);
   assign bus.out_mem_req_addr  = req_addr_reg;
   assign bus.out_instr_valid   = (count_reg != '0);
   assign bus.out_instr         = head_instr_reg;
   assign bus.out_instr_pc      = head_pc_reg;

endmodule

// File: tb/tb_snow64_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_snow64_instr_fetch
// Directed bench for snow64_instr_fetch. A small memory model inside the
// per-cycle tick task answers each accepted request after mem_lat cycles with
// data = addr >> 2. Every accepted request and every decoder pop is logged.
// ----------------------------------------------------------------------------
module tb_snow64_instr_fetch;

   logic clk;
   logic rst;

   snow64_instr_fetch_if #(.WIDTH__INSTR(32), .WIDTH__ADDR(64)) bus ();

   snow64_instr_fetch #(
      .WIDTH__INSTR(32),
      .WIDTH__ADDR (64),
      .RESET_PC    (64'h0),
      .FIFO_DEPTH  (4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_asserts = 0;
   int n_fail    = 0;

   logic [63:0] acc_q[$];
   logic [63:0] pop_pc_q[$];
   logic [31:0] pop_instr_q[$];

   int          mem_lat = 1;
   logic        pend    = 1'b0;
   int          due     = 0;
   logic [63:0] paddr   = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: sample handshakes before the edge, update stimulus #1
   // after it.
   task automatic tick();
      logic        acc;
      logic [63:0] a;
      logic        pp;
      logic [63:0] ppc;
      logic [31:0] pin;
      acc = !rst && bus.out_mem_req_valid && bus.in_mem_req_ready;
      a   = bus.out_mem_req_addr;
      pp  = !rst && bus.out_instr_valid && bus.in_instr_ready;
      ppc = bus.out_instr_pc;
      pin = bus.out_instr;
      @(posedge clk);
      #1;
      if (acc) begin
         acc_q.push_back(a);
         $display("req accepted addr=%h", a);
      end
      if (pp) begin
         pop_pc_q.push_back(ppc);
         pop_instr_q.push_back(pin);
         $display("pop pc=%h instr=%h", ppc, pin);
      end
      bus.in_mem_resp_valid = 1'b0;
      if (rst) begin
         pend = 1'b0;
      end else begin
         if (acc) begin
            pend  = 1'b1;
            due   = mem_lat;
            paddr = a;
         end
         if (pend) begin
            due--;
            if (due == 0) begin
               bus.in_mem_resp_valid = 1'b1;
               bus.in_mem_resp_data  = paddr[33:2];
               pend = 1'b0;
            end
         end
      end
   endtask

   task automatic clear_logs();
      acc_q.delete();
      pop_pc_q.delete();
      pop_instr_q.delete();
   endtask

   // Leaves rst low at the start of the first post-reset cycle.
   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      clear_logs();
      rst = 1'b0;
   endtask

   task automatic run_until_pops(input int n, input int budget, input string tag);
      int c;
      c = 0;
      while (pop_pc_q.size() < n && c < budget) begin
         tick();
         c++;
      end
      check(tag, 64'(pop_pc_q.size() >= n), 64'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_valid"},   64'(bus.out_mem_req_valid), 64'd0);
      check({tag, "_req_addr"},    bus.out_mem_req_addr,       64'h0);
      check({tag, "_instr_valid"}, 64'(bus.out_instr_valid),   64'd0);
      check({tag, "_instr"},       64'(bus.out_instr),         64'h0);
      check({tag, "_instr_pc"},    bus.out_instr_pc,           64'h0);
   endtask

   initial begin
      int c;
      rst                   = 1'b1;
      bus.in_redirect_valid = 1'b0;
      bus.in_redirect_addr  = '0;
      bus.in_mem_req_ready  = 1'b1;
      bus.in_mem_resp_valid = 1'b0;
      bus.in_mem_resp_data  = '0;
      bus.in_instr_ready    = 1'b0;

      // ---------------- reset state ----------------
      tick();
      tick();
      tick();
      check_reset_outputs("rst");

      // ---------------- 1: basic fetch ----------------
      clear_logs();
      mem_lat = 1;
      bus.in_instr_ready = 1'b1;
      rst = 1'b0;
      check("t1_cycle0_req_valid", 64'(bus.out_mem_req_valid), 64'd0);
      tick();
      check("t1_cycle1_req_valid", 64'(bus.out_mem_req_valid), 64'd1);
      check("t1_cycle1_req_addr",  bus.out_mem_req_addr,       64'h0);
      run_until_pops(3, 30, "t1_pop_timeout");
      check("t1_acc0",    acc_q[0],       64'h0);
      check("t1_acc1",    acc_q[1],       64'h4);
      check("t1_acc2",    acc_q[2],       64'h8);
      check("t1_pop0_pc", pop_pc_q[0],    64'h0);
      check("t1_pop0_in", 64'(pop_instr_q[0]), 64'h0);
      check("t1_pop1_pc", pop_pc_q[1],    64'h4);
      check("t1_pop1_in", 64'(pop_instr_q[1]), 64'h1);
      check("t1_pop2_pc", pop_pc_q[2],    64'h8);
      check("t1_pop2_in", 64'(pop_instr_q[2]), 64'h2);

      // ---------------- 2: full FIFO back-pressure ----------------
      bus.in_instr_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 20; i++) tick();
      check("t2_accepts",     64'(acc_q.size()),          64'd4);
      check("t2_req_idle",    64'(bus.out_mem_req_valid), 64'd0);
      check("t2_instr_valid", 64'(bus.out_instr_valid),   64'd1);
      check("t2_head_pc",     bus.out_instr_pc,           64'h0);
      bus.in_instr_ready = 1'b1;
      tick();
      bus.in_instr_ready = 1'b0;
      check("t2_pop_pc",      pop_pc_q[0],                64'h0);
      check("t2_new_head_pc", bus.out_instr_pc,           64'h4);
      check("t2_new_head_in", 64'(bus.out_instr),         64'h1);
      c = 0;
      while (!bus.out_mem_req_valid && c < 5) begin
         tick();
         c++;
      end
      check("t2_restart_valid", 64'(bus.out_mem_req_valid), 64'd1);
      check("t2_restart_addr",  bus.out_mem_req_addr,       64'h10);

      // ---------------- 3: redirect during WAIT ----------------
      mem_lat = 3;
      bus.in_instr_ready = 1'b1;
      do_reset();
      c = 0;
      while (acc_q.size() < 1 && c < 10) begin
         tick();
         c++;
      end
      check("t3_first_accept", 64'(acc_q.size()), 64'd1);
      bus.in_redirect_valid = 1'b1;
      bus.in_redirect_addr  = 64'h1002;
      tick();
      bus.in_redirect_valid = 1'b0;
      check("t3_flushed_valid", 64'(bus.out_instr_valid), 64'd0);
      run_until_pops(2, 40, "t3_pop_timeout");
      check("t3_acc1",    acc_q[1],               64'h1000);
      check("t3_pop0_pc", pop_pc_q[0],            64'h1000);
      check("t3_pop0_in", 64'(pop_instr_q[0]),    64'h400);
      check("t3_pop1_pc", pop_pc_q[1],            64'h1004);
      check("t3_pop1_in", 64'(pop_instr_q[1]),    64'h401);

      // ---------------- 4: redirect + response + pop together ----------------
      mem_lat = 1;
      bus.in_instr_ready = 1'b0;
      do_reset();
      c = 0;
      while (!(bus.in_mem_resp_valid && bus.out_instr_valid) && c < 20) begin
         tick();
         c++;
      end
      check("t4_setup", 64'(bus.in_mem_resp_valid && bus.out_instr_valid), 64'd1);
      bus.in_redirect_valid = 1'b1;
      bus.in_redirect_addr  = 64'h2000;
      bus.in_instr_ready    = 1'b1;
      tick();
      bus.in_redirect_valid = 1'b0;
      bus.in_instr_ready    = 1'b0;
      check("t4_pop_count",    64'(pop_pc_q.size()),        64'd1);
      check("t4_pop_pc",       pop_pc_q[0],                 64'h0);
      check("t4_flushed",      64'(bus.out_instr_valid),    64'd0);
      check("t4_req_valid",    64'(bus.out_mem_req_valid),  64'd1);
      check("t4_req_addr",     bus.out_mem_req_addr,        64'h2000);
      bus.in_instr_ready = 1'b1;
      run_until_pops(2, 20, "t4_pop_timeout");
      check("t4_next_pc",      pop_pc_q[1],                 64'h2000);
      check("t4_next_in",      64'(pop_instr_q[1]),         64'h800);

      // ---------------- 5: address wrap ----------------
      mem_lat = 1;
      bus.in_instr_ready = 1'b1;
      do_reset();
      bus.in_redirect_valid = 1'b1;
      bus.in_redirect_addr  = 64'hFFFF_FFFF_FFFF_FFFC;
      tick();
      bus.in_redirect_valid = 1'b0;
      check("t5_req_addr", bus.out_mem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      run_until_pops(2, 30, "t5_pop_timeout");
      check("t5_acc0",    acc_q[0],            64'hFFFF_FFFF_FFFF_FFFC);
      check("t5_acc1",    acc_q[1],            64'h0);
      check("t5_pop0_pc", pop_pc_q[0],         64'hFFFF_FFFF_FFFF_FFFC);
      check("t5_pop0_in", 64'(pop_instr_q[0]), 64'hFFFF_FFFF);
      check("t5_pop1_pc", pop_pc_q[1],         64'h0);
      check("t5_pop1_in", 64'(pop_instr_q[1]), 64'h0);

      // ---------------- 6: reset with a stalled request ----------------
      bus.in_mem_req_ready = 1'b0;
      bus.in_instr_ready   = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      check("t6_stalled_req", 64'(bus.out_mem_req_valid), 64'd1);
      rst = 1'b1;
      tick();
      check_reset_outputs("t6_rst");
      clear_logs();
      bus.in_mem_req_ready = 1'b1;
      bus.in_instr_ready   = 1'b1;
      rst = 1'b0;
      tick();
      check("t6_restart_valid", 64'(bus.out_mem_req_valid), 64'd1);
      check("t6_restart_addr",  bus.out_mem_req_addr,       64'h0);
      run_until_pops(1, 20, "t6_pop_timeout");
      check("t6_pop_pc", pop_pc_q[0],         64'h0);
      check("t6_pop_in", 64'(pop_instr_q[0]), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
